// File: rtl/bcd_countdown_timer_if.sv
// Keypad, tick and display signals of the m:ss countdown timer, grouped for one port.
interface bcd_countdown_timer_if #(
  parameter int unsigned MIN_DIGITS = 1
) ();
  logic                    loadn;
  logic                    key_valid;
  logic [3:0]              data;
  logic                    en;
  logic                    add30;
  logic [3:0]              sec_ones;
  logic [3:0]              sec_tens;
  logic [4*MIN_DIGITS-1:0] mins;
  logic                    zero;
  logic                    tc;

  modport master (
    output loadn, key_valid, data, en, add30,
    input  sec_ones, sec_tens, mins, zero, tc
  );

  modport slave (
    input  loadn, key_valid, data, en, add30,
    output sec_ones, sec_tens, mins, zero, tc
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD m:ss countdown timer: keypad shift-in load, prescaled decrement, add-30s and
// a registered terminal-count pulse.
module bcd_countdown_timer #(
  parameter int unsigned MIN_DIGITS    = 1,
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned PW            = 10
) (
  input  logic                 clk,
  input  logic                 clrn,
  bcd_countdown_timer_if.slave tmr
);
  localparam int unsigned      MW    = 4 * MIN_DIGITS;
  localparam logic [MW-1:0]    NINES = {MIN_DIGITS{4'h9}};

  typedef enum logic [1:0] {PH_LOAD, PH_NORM, PH_RUN} phase_e;

  logic [3:0]    so_q, so_d, st_q, st_d;
  logic [MW-1:0] mins_q, mins_d;
  logic [PW-1:0] ps_q, ps_d;
  logic          tc_q, tc_d;
  logic          loadn_q;
  logic          zero;
  logic          tick;
  phase_e        phase;
  logic [MW:0]   inc_r;
  logic [3:0]    a_so, a_st;
  logic [MW-1:0] a_m;

  // Returns {carry_out, incremented digits}.
  function automatic logic [MW:0] bcd_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          c;
    r = m;
    c = 1'b1;
    for (int unsigned k = 0; k < MIN_DIGITS; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [MW-1:0] bcd_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          b;
    r = m;
    b = 1'b1;
    for (int unsigned k = 0; k < MIN_DIGITS; k++) begin
      if (b) begin
        if (r[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    so_d   = so_q;
    st_d   = st_q;
    mins_d = mins_q;
    ps_d   = ps_q;
    tc_d   = 1'b0;
    tick   = 1'b0;
    inc_r  = '0;
    a_so   = so_q;
    a_st   = st_q;
    a_m    = mins_q;
    zero   = (so_q == 4'd0) && (st_q == 4'd0) && (mins_q == '0);

    if (!tmr.loadn)    phase = PH_LOAD;
    else if (!loadn_q) phase = PH_NORM;
    else               phase = PH_RUN;

    case (phase)
      PH_LOAD: begin
        ps_d = '0;
        if (tmr.key_valid && (tmr.data <= 4'd9)) begin
          so_d   = tmr.data;
          st_d   = so_q;
          mins_d = MW'({mins_q, st_q});
        end
      end
      PH_NORM: begin
        if (st_q > 4'd5) begin
          st_d   = st_q - 4'd6;
          inc_r  = bcd_inc(mins_q);
          mins_d = inc_r[MW] ? NINES : inc_r[MW-1:0];
        end
      end
      PH_RUN: begin
        if (tmr.en && !zero) begin
          if (ps_q == PW'(TICKS_PER_SEC - 1)) begin
            tick = 1'b1;
            ps_d = '0;
          end else begin
            ps_d = ps_q + PW'(1);
          end
        end
        // Add is resolved (including saturation) before the same-cycle decrement.
        if (tmr.add30) begin
          if (st_q >= 4'd3) begin
            a_st  = st_q - 4'd3;
            inc_r = bcd_inc(mins_q);
            if (inc_r[MW]) begin
              a_m  = NINES;
              a_st = 4'd5;
              a_so = 4'd9;
            end else begin
              a_m = inc_r[MW-1:0];
            end
          end else begin
            a_st = st_q + 4'd3;
          end
        end
        if (tick) begin
          if (a_so != 4'd0) begin
            a_so = a_so - 4'd1;
          end else if (a_st != 4'd0) begin
            a_so = 4'd9;
            a_st = a_st - 4'd1;
          end else begin
            a_so = 4'd9;
            a_st = 4'd5;
            a_m  = bcd_dec(a_m);
          end
          tc_d = (a_so == 4'd0) && (a_st == 4'd0) && (a_m == '0);
        end
        so_d   = a_so;
        st_d   = a_st;
        mins_d = a_m;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      so_q    <= '0;
      st_q    <= '0;
      mins_q  <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      loadn_q <= 1'b0;
    end else begin
      so_q    <= so_d;
      st_q    <= st_d;
      mins_q  <= mins_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
      loadn_q <= tmr.loadn;
    end
  end

  assign tmr.sec_ones = so_q;
  assign tmr.sec_tens = st_q;
  assign tmr.mins     = mins_q;
  assign tmr.zero     = zero;
  assign tmr.tc       = tc_q;
endmodule
